// File: rtl/apb4_mux_wdt.sv
// APB4 slave mux: priority decode, default-slave error for holes,
// and a per-transfer watchdog that aborts stuck slave accesses.
module apb4_mux_wdt #(
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 8,
  parameter int SLAVES     = 8,
  parameter int TIMEOUT    = 16,
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic                                 PCLK,
  input  logic                                 PRESET,
  input  logic                                 MST_PSEL,
  input  logic                                 MST_PENABLE,
  input  logic [PADDR_SIZE-1:0]                MST_PADDR,
  output logic [PDATA_SIZE-1:0]                MST_PRDATA,
  output logic                                 MST_PREADY,
  output logic                                 MST_PSLVERR,
  input  logic [SLAVES-1:0][PADDR_SIZE-1:0]    slv_addr,
  input  logic [SLAVES-1:0][PADDR_SIZE-1:0]    slv_mask,
  output logic [SLAVES-1:0]                    SLV_PSEL,
  input  logic [SLAVES-1:0][PDATA_SIZE-1:0]    SLV_PRDATA,
  input  logic [SLAVES-1:0]                    SLV_PREADY,
  input  logic [SLAVES-1:0]                    SLV_PSLVERR,
  output logic                                 ERR_UNMAPPED,
  output logic                                 ERR_TIMEOUT,
  output logic [SW-1:0]                        ERR_SLV
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ABORT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [SW-1:0]   idx_r;
  logic [SW-1:0]   idx_nxt;
  logic [SW-1:0]   sel_idx;
  logic [SLAVES-1:0] hit;
  logic [SLAVES-1:0] sel;
  logic            mapped;
  logic            rdy_idx;
  logic            unm_set;
  logic            to_set;

  // Lowest index wins: scan downward so the last write is the winner.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    for (int i = 0; i < SLAVES; i++) begin
      hit[i] = ((MST_PADDR & slv_mask[i]) ==
                (slv_addr[i] & slv_mask[i]));
    end
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel     = '0;
        sel[i]  = 1'b1;
        sel_idx = SW'(i);
      end
    end
    mapped = |hit;
  end

  always_comb begin
    rdy_idx = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      if (idx_r == SW'(i)) rdy_idx = SLV_PREADY[i];
    end
  end

  assign SLV_PSEL = (MST_PSEL && state != ABORT) ? sel : '0;

  always_comb begin
    MST_PREADY  = 1'b0;
    MST_PSLVERR = 1'b0;
    MST_PRDATA  = '0;
    if (MST_PSEL) begin
      if (state == ABORT) begin
        MST_PREADY  = 1'b1;
        MST_PSLVERR = 1'b1;
      end else if (mapped) begin
        MST_PREADY  = |(SLV_PREADY & sel);
        MST_PSLVERR = |(SLV_PSLVERR & sel) & MST_PREADY;
        for (int i = 0; i < SLAVES; i++) begin
          MST_PRDATA = MST_PRDATA |
                       (SLV_PRDATA[i] & {PDATA_SIZE{sel[i]}});
        end
      end else if (MST_PENABLE) begin
        MST_PREADY  = 1'b1;
        MST_PSLVERR = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx_r;
    unm_set   = 1'b0;
    to_set    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        unm_set = MST_PSEL & MST_PENABLE & ~mapped;
        if (MST_PSEL && !MST_PENABLE && mapped) begin
          state_nxt = ACCESS;
          idx_nxt   = sel_idx;
        end
      end
      ACCESS: begin
        if (!MST_PSEL) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (MST_PENABLE && MST_PREADY) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (MST_PENABLE && !rdy_idx) begin
          if (TIMEOUT != 0 && cnt == TMAX) begin
            state_nxt = ABORT;
          end else if (cnt != TMAX) begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      ABORT: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        to_set    = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state        <= IDLE;
      cnt          <= '0;
      idx_r        <= '0;
      ERR_UNMAPPED <= 1'b0;
      ERR_TIMEOUT  <= 1'b0;
      ERR_SLV      <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx_r        <= idx_nxt;
      ERR_UNMAPPED <= unm_set;
      ERR_TIMEOUT  <= to_set;
      if (to_set) ERR_SLV <= idx_r;
    end
  end

endmodule

// File: tb/tb_apb4_mux_wdt.sv
// Bench for apb4_mux_wdt: two instances (TIMEOUT=4 and 0) on one bus,
// checked each cycle against a transfer-level reference model.
module tb_apb4_mux_wdt;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              m_psel;
  logic              m_pen;
  logic [7:0]        m_addr;
  logic [S-1:0][7:0] sa;
  logic [S-1:0][7:0] sm;
  logic [S-1:0][7:0] s_dat;
  logic [S-1:0]      s_rdy;
  logic [S-1:0]      s_err;

  logic [7:0] d_dat [2];
  logic       d_rdy [2];
  logic       d_err [2];
  logic       d_eu  [2];
  logic       d_et  [2];
  logic [3:0] d_psel[2];
  logic [1:0] d_es  [2];

  apb4_mux_wdt #(.PADDR_SIZE(8), .PDATA_SIZE(8), .SLAVES(S),
                 .TIMEOUT(4)) dut_a (
    .PCLK(clk), .PRESET(rst),
    .MST_PSEL(m_psel), .MST_PENABLE(m_pen), .MST_PADDR(m_addr),
    .MST_PRDATA(d_dat[0]), .MST_PREADY(d_rdy[0]),
    .MST_PSLVERR(d_err[0]),
    .slv_addr(sa), .slv_mask(sm), .SLV_PSEL(d_psel[0]),
    .SLV_PRDATA(s_dat), .SLV_PREADY(s_rdy), .SLV_PSLVERR(s_err),
    .ERR_UNMAPPED(d_eu[0]), .ERR_TIMEOUT(d_et[0]),
    .ERR_SLV(d_es[0])
  );

  apb4_mux_wdt #(.PADDR_SIZE(8), .PDATA_SIZE(8), .SLAVES(S),
                 .TIMEOUT(0)) dut_b (
    .PCLK(clk), .PRESET(rst),
    .MST_PSEL(m_psel), .MST_PENABLE(m_pen), .MST_PADDR(m_addr),
    .MST_PRDATA(d_dat[1]), .MST_PREADY(d_rdy[1]),
    .MST_PSLVERR(d_err[1]),
    .slv_addr(sa), .slv_mask(sm), .SLV_PSEL(d_psel[1]),
    .SLV_PRDATA(s_dat), .SLV_PREADY(s_rdy), .SLV_PSLVERR(s_err),
    .ERR_UNMAPPED(d_eu[1]), .ERR_TIMEOUT(d_et[1]),
    .ERR_SLV(d_es[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", n, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] psel;
    logic       rdy;
    logic       err;
    logic [7:0] dat;
  } resp_t;

  // Model: per instance, an open transfer with its slave and stall count.
  bit         m_busy[2];
  bit         m_abt [2];
  int         m_w   [2];
  int         m_idx [2];
  logic       m_eu  [2];
  logic       m_et  [2];
  logic [1:0] m_es  [2];

  function automatic int tmo(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic int dec();
    for (int i = 0; i < S; i++)
      if ((m_addr & sm[i]) == (sa[i] & sm[i])) return i;
    return -1;
  endfunction

  function automatic resp_t exp_resp(input int k);
    resp_t r;
    int s;
    r = '0;
    s = dec();
    if (!m_psel) return r;
    if (m_abt[k]) begin
      r.rdy = 1'b1;
      r.err = 1'b1;
      return r;
    end
    if (s >= 0) begin
      r.psel[s] = 1'b1;
      r.rdy     = s_rdy[s];
      r.err     = s_err[s] & s_rdy[s];
      r.dat     = s_dat[s];
    end else if (m_pen) begin
      r.rdy = 1'b1;
      r.err = 1'b1;
    end
    return r;
  endfunction

  function automatic bit exp_rdy(input int k);
    resp_t r;
    r = exp_resp(k);
    return r.rdy;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 1'b0;
        m_abt[k]  <= 1'b0;
        m_w[k]    <= 0;
        m_idx[k]  <= 0;
        m_eu[k]   <= 1'b0;
        m_et[k]   <= 1'b0;
        m_es[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_eu[k] <= !m_busy[k] && !m_abt[k] && m_psel && m_pen
                   && dec() < 0;
        m_et[k] <= m_abt[k];
        if (m_abt[k]) begin
          m_es[k]  <= 2'(m_idx[k]);
          m_abt[k] <= 1'b0;
        end else if (!m_busy[k]) begin
          if (m_psel && !m_pen && dec() >= 0) begin
            m_busy[k] <= 1'b1;
            m_w[k]    <= 0;
            m_idx[k]  <= dec();
          end
        end else if (!m_psel) begin
          m_busy[k] <= 1'b0;
        end else if (m_pen && exp_rdy(k)) begin
          m_busy[k] <= 1'b0;
        end else if (m_pen && !s_rdy[m_idx[k]]) begin
          if (tmo(k) > 0 && m_w[k] == tmo(k)) begin
            m_busy[k] <= 1'b0;
            m_abt[k]  <= 1'b1;
          end else begin
            m_w[k] <= m_w[k] + 1;
          end
        end
      end
    end
  end

  bit         want_post = 1'b0;
  int         post_k    = 0;
  logic       p_eu;
  logic       p_et;
  logic [1:0] p_es;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      resp_t r;
      r = exp_resp(k);
      chk(k == 0 ? "a_psel" : "b_psel", d_psel[k], r.psel);
      chk(k == 0 ? "a_ready" : "b_ready", d_rdy[k], r.rdy);
      chk(k == 0 ? "a_slverr" : "b_slverr", d_err[k], r.err);
      chk(k == 0 ? "a_rdata" : "b_rdata", d_dat[k], r.dat);
      chk(k == 0 ? "a_err_unm" : "b_err_unm", d_eu[k], m_eu[k]);
      chk(k == 0 ? "a_err_to" : "b_err_to", d_et[k], m_et[k]);
      chk(k == 0 ? "a_err_slv" : "b_err_slv", d_es[k], m_es[k]);
    end
    if (want_post) begin
      p_eu      = d_eu[post_k];
      p_et      = d_et[post_k];
      p_es      = d_es[post_k];
      want_post = 1'b0;
    end
  end

  logic [3:0] su_psel;
  logic [7:0] su_dat;
  int         la_n;
  logic [3:0] la_psel;
  logic       la_rdy;
  logic       la_err;
  logic [7:0] la_dat;

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Master follows the model's PREADY of instance cur.
  task automatic xfer(input logic [7:0] a, input int stall,
                      input int cur, input int gap);
    int acc;
    bit done;
    m_psel = 1'b1;
    m_pen  = 1'b0;
    m_addr = a;
    s_rdy  = 4'($urandom);
    @(negedge clk);
    su_psel = d_psel[cur];
    su_dat  = d_dat[cur];
    next_cyc();
    m_pen = 1'b1;
    acc   = 0;
    done  = 1'b0;
    while (!done) begin
      s_rdy = (acc >= stall) ? 4'hF : 4'h0;
      @(negedge clk);
      if (exp_rdy(cur)) begin
        done    = 1'b1;
        la_n    = acc + 1;
        la_psel = d_psel[cur];
        la_rdy  = d_rdy[cur];
        la_err  = d_err[cur];
        la_dat  = d_dat[cur];
      end
      next_cyc();
      acc++;
      if (!done && acc > 300) begin
        total++;
        bad++;
        $display("FAIL xfer_bound act=%0d exp<=300", acc);
        done = 1'b1;
      end
    end
    want_post = 1'b1;
    post_k    = cur;
    m_psel    = 1'b0;
    m_pen     = 1'b0;
    s_rdy     = 4'($urandom);
    repeat (gap) next_cyc();
  endtask

  initial begin
    #2000000;
    $display("FAIL sim_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    m_psel = 1'b0;
    m_pen  = 1'b0;
    m_addr = '0;
    sa     = {8'h80, 8'h20, 8'h48, 8'h40};
    sm     = {8'h80, 8'hE0, 8'hF8, 8'hC0};
    s_dat  = {8'h33, 8'hA5, 8'h22, 8'h11};
    s_rdy  = '0;
    s_err  = '0;
    @(negedge clk);
    chk("rst_unm", d_eu[0], 0);
    chk("rst_to", d_et[0], 0);
    chk("rst_slv", d_es[0], 0);
    chk("rst_rdy", d_rdy[1], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    next_cyc();

    xfer(8'h4A, 0, 0, 1);
    chk("prio_psel", su_psel, 4'b0001);
    chk("prio_dat", su_dat, 8'h11);
    chk("prio_n", la_n, 1);

    xfer(8'h25, 3, 0, 1);
    chk("wait_n", la_n, 4);
    chk("wait_dat", la_dat, 8'hA5);
    chk("wait_err", la_err, 0);
    chk("wait_to", p_et, 0);

    xfer(8'h05, 0, 0, 2);
    chk("unm_psel", su_psel, 0);
    chk("unm_n", la_n, 1);
    chk("unm_rdy", la_rdy, 1);
    chk("unm_err", la_err, 1);
    chk("unm_dat", la_dat, 0);
    chk("unm_pulse", p_eu, 1);

    xfer(8'h90, 1000, 0, 1);
    chk("to_n", la_n, 6);
    chk("to_rdy", la_rdy, 1);
    chk("to_err", la_err, 1);
    chk("to_psel", la_psel, 0);
    chk("to_pulse", p_et, 1);
    chk("to_slv", p_es, 3);

    xfer(8'h25, 100, 1, 1);
    chk("t0_n", la_n, 101);
    chk("t0_dat", la_dat, 8'hA5);
    chk("t0_err", la_err, 0);
    chk("t0_pulse", p_et, 0);

    m_psel = 1'b1;
    m_pen  = 1'b0;
    m_addr = 8'h25;
    next_cyc();
    m_pen = 1'b1;
    s_rdy = '0;
    next_cyc();
    next_cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_to", d_et[0], 0);
    next_cyc();
    rst    = 1'b0;
    m_psel = 1'b0;
    m_pen  = 1'b0;
    next_cyc();
    xfer(8'h25, 2, 0, 1);
    chk("rstmid_n", la_n, 3);
    chk("rstmid_dat", la_dat, 8'hA5);
    chk("rstmid_pulse", p_et, 0);

    sa = {8'h80, 8'h20, 8'h08, 8'h00};
    sm = {8'h80, 8'hE0, 8'hE0, 8'hF0};
    for (int n = 0; n < 150; n++) begin
      s_dat = {$urandom, $urandom};
      s_err = 4'($urandom);
      xfer(8'($urandom), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 2));
    end
    next_cyc();
    next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
